// File: rtl/ws2812_bit_sched_if.sv
// Pixel RAM read port plus the per-bit handshake toward ws2812_out.
// The master side is the scheduler; the slave side is the RAM and the bit encoder.
interface ws2812_bit_sched_if #(
    parameter int ADDR_W = 8
);
    logic              pix_rd_en_out;
    logic [ADDR_W-1:0] pix_rd_addr_out;
    logic [23:0]       pix_data_in;
    logic              bit_rdy_out;
    logic              bit_data_out;
    logic              bit_done_in;

    modport master (
        output pix_rd_en_out,
        output pix_rd_addr_out,
        input  pix_data_in,
        output bit_rdy_out,
        output bit_data_out,
        input  bit_done_in
    );

    modport slave (
        input  pix_rd_en_out,
        input  pix_rd_addr_out,
        output pix_data_in,
        input  bit_rdy_out,
        input  bit_data_out,
        output bit_done_in
    );
endinterface

// File: rtl/ws2812_bit_sched.sv
// WS2812 frame scheduler: fetches PIXEL_CNT GRB words, issues them MSB first one bit per bit_done, then holds the reset gap.
// Start-to-first-bit 3 cycles; stalls in WAIT on the encoder; optional per-bit watchdog under WS2812_SCHED_WDT_EN.
module ws2812_bit_sched #(
    parameter int PIXEL_CNT   = 64,
    parameter int ADDR_W      = 8,
    parameter int CNT_RST_GAP = 16000,
    parameter int CNT_BIT_TMO = 1024
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    ws2812_bit_sched_if.master  bus,
    output logic                frame_busy_out,
    output logic                frame_done_out,
    output logic                frame_err_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXEL_CNT - 1);
    // Outputs are registered, so terminal counts are decided one cycle early.
    localparam logic [15:0] GAP_LAST = (CNT_RST_GAP > 1) ? 16'(CNT_RST_GAP - 2) : 16'd0;
    localparam bit          GAP_ONE  = (CNT_RST_GAP == 1);

    if (CNT_BIT_TMO < 2) begin : g_bad_tmo
        $error("CNT_BIT_TMO must be at least 2");
    end

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       shift;
    logic [4:0]        bit_idx;
    logic [15:0]       gap_cnt;

`ifdef WS2812_SCHED_WDT_EN
    localparam logic [15:0] WDT_LAST = 16'(CNT_BIT_TMO - 2);
    logic [15:0] wdt_cnt;
`else
    assign frame_err_out = 1'b0;
`endif

    assign bus.pix_rd_addr_out = addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= S_IDLE;
            addr               <= '0;
            shift              <= '0;
            bit_idx            <= '0;
            gap_cnt            <= '0;
            bus.pix_rd_en_out  <= 1'b0;
            bus.bit_rdy_out    <= 1'b0;
            bus.bit_data_out   <= 1'b0;
            frame_busy_out     <= 1'b0;
            frame_done_out     <= 1'b0;
`ifdef WS2812_SCHED_WDT_EN
            wdt_cnt            <= '0;
            frame_err_out      <= 1'b0;
`endif
        end else begin
            bus.pix_rd_en_out <= 1'b0;
            bus.bit_rdy_out   <= 1'b0;
            frame_done_out    <= 1'b0;
`ifdef WS2812_SCHED_WDT_EN
            frame_err_out     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // The done cycle itself still counts as the old frame.
                    if (frame_start_in && !frame_done_out) begin
                        addr              <= '0;
                        bus.pix_rd_en_out <= 1'b1;
                        frame_busy_out    <= 1'b1;
                        state             <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    shift            <= bus.pix_data_in;
                    bit_idx          <= 5'd23;
                    bus.bit_rdy_out  <= 1'b1;
                    bus.bit_data_out <= bus.pix_data_in[23];
                    state            <= S_SEND;
                end
                S_SEND: begin
`ifdef WS2812_SCHED_WDT_EN
                    wdt_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.bit_done_in) begin
                        if (bit_idx != 5'd0) begin
                            shift            <= shift << 1;
                            bit_idx          <= bit_idx - 5'd1;
                            bus.bit_rdy_out  <= 1'b1;
                            bus.bit_data_out <= shift[22];
                            state            <= S_SEND;
                        end else if (addr != ADDR_LAST) begin
                            addr              <= addr + ADDR_W'(1);
                            bus.pix_rd_en_out <= 1'b1;
                            state             <= S_FETCH;
                        end else if (GAP_ONE) begin
                            frame_done_out <= 1'b1;
                            frame_busy_out <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
`ifdef WS2812_SCHED_WDT_EN
                    else if (wdt_cnt == WDT_LAST) begin
                        frame_err_out  <= 1'b1;
                        frame_busy_out <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 16'd1;
                    end
`endif
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        frame_done_out <= 1'b1;
                        frame_busy_out <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ws2812_bit_sched.md
# ws2812_bit_sched

Frame-level scheduler that feeds the WS2812 bit encoder. On a frame start it reads PIXEL_CNT 24-bit GRB words from the pixel RAM, one per pixel, and hands them bit by bit to `ws2812_out` over the `bit_rdy`/`bit_data`/`bit_done` handshake, MSB first. After the last pixel it holds off for the latch/reset gap. It then signals frame completion.

## Interface
- `PIXEL_CNT`, 64: pixels per frame, 1..2^ADDR_W.
- `ADDR_W`, 8: pixel RAM address width.
- `CNT_RST_GAP`, 16000: reset-gap length in clk_in cycles (80 µs at 200 MHz), 16-bit, ≥1.
- `CNT_BIT_TMO`, 1024: watchdog limit in cycles per bit; used only with WS2812_SCHED_WDT_EN.
- `clk_in`  in  1  system clock (same clock as `ws2812_out`).
- `rst_in`  in  1  synchronous, active-high reset.
- `frame_start_in`  in  1  single-cycle request to send one frame.
- `pix_rd_en_out`  out  1  pixel RAM read strobe.
- `pix_rd_addr_out`  out  ADDR_W  pixel RAM read address.
- `pix_data_in`  in  24  pixel RAM read data, valid exactly 1 cycle after `pix_rd_en_out`.
- `bit_rdy_out`  out  1  one-cycle pulse that starts a bit in `ws2812_out`.
- `bit_data_out`  out  1  bit value. Held stable from the `bit_rdy_out` cycle until `bit_done_in`.
- `bit_done_in`  in  1  one-cycle pulse from `ws2812_out` at the end of a bit.
- `frame_busy_out`  out  1  high from the first cycle after an accepted start until `frame_done_out`.
- `frame_done_out`  out  1  one-cycle pulse at the end of the reset gap.
- `frame_err_out`  out  1  one-cycle pulse on a watchdog abort. Tied 0 without WS2812_SCHED_WDT_EN.

## Operation
- States:
  - IDLE: outputs idle. `frame_start_in` sets addr←0 and moves to FETCH. Start is ignored in every other state.
  - FETCH: `pix_rd_en_out`=1 for one cycle with the current addr, then LATCH.
  - LATCH: shift←`pix_data_in`, bit_idx←23, then SEND.
  - SEND: `bit_rdy_out`=1 for one cycle, `bit_data_out`←shift[23], then WAIT.
  - WAIT: on `bit_done_in`:
    - bit_idx≠0: shift←shift<<1, bit_idx−1, go to SEND.
    - bit_idx=0 and addr≠PIXEL_CNT−1: addr+1, go to FETCH.
    - bit_idx=0 and addr=PIXEL_CNT−1: gap_cnt←0, go to GAP.
  - GAP: gap_cnt increments each cycle. At gap_cnt=CNT_RST_GAP−1, pulse `frame_done_out`, clear busy, go to IDLE.
- `bit_done_in` outside WAIT is ignored.
- Bit order within a pixel is bit 23 down to bit 0. Pixel order is address 0 up to PIXEL_CNT−1.
- Counter widths:
  - addr is ADDR_W.
  - bit_idx is 5 bits.
  - gap_cnt and wdt_cnt are 16 bits, with no wrap in legal use.
- Reset in any state forces IDLE on the next edge. All outputs are 0, counters are 0, and `bit_data_out`=0. A bit already in flight in `ws2812_out` completes on its own; its `bit_done_in` is then ignored in IDLE.

## Timing
- Reset values: every output is 0.
- `frame_start_in` sampled at edge 0 gives:
  - `frame_busy_out` high from edge 1.
  - `pix_rd_en_out` high from edge 1.
  - first `bit_rdy_out` at edge 3.
- Within a pixel, `bit_done_in` at edge n puts the next `bit_rdy_out` at n+1.
- Across a pixel boundary, `bit_done_in` at edge n gives the read at n+1 and `bit_rdy_out` at n+3.
- After the last `bit_done_in` at edge n, `frame_done_out` pulses at edge n+CNT_RST_GAP, and `frame_busy_out` falls on the same edge.
- A new `frame_start_in` is accepted from the cycle after `frame_done_out`.

## Configuration
- `WS2812_SCHED_WDT_EN` defined:
  - wdt_cnt clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches CNT_BIT_TMO−1 without `bit_done_in`, the block pulses `frame_err_out`, drops `frame_busy_out`, and goes to IDLE. No `frame_done_out` is issued.
  - `bit_done_in` in the same cycle as the limit wins: normal progress, no error.
- `WS2812_SCHED_WDT_EN` undefined:
  - WAIT waits indefinitely.
  - `frame_err_out` is constant 0 and no watchdog logic is synthesized.

## Test plan
- Reset: hold `rst_in` 3 cycles mid-frame → all outputs 0 the next cycle, and no `bit_rdy_out` until a new start.
- Single frame, PIXEL_CNT=2, RAM[0]=0xA500FF, RAM[1]=0x000001, bench `ws2812_out` model answering `bit_done_in` 5 cycles after each `bit_rdy_out` → 48 `bit_rdy_out` pulses carrying 1010_0101_0000_0000_1111_1111 then 23 zeros and a 1.
- Same frame as above → reads at addr 0 then 1, first `bit_rdy_out` 3 cycles after start, `frame_done_out` exactly CNT_RST_GAP cycles after the 48th `bit_done_in`.
- `frame_start_in` pulsed while busy and during GAP → ignored: exactly one `frame_done_out`, 48 bits. A start the cycle after `frame_done_out` → new frame begins.
- Spurious `bit_done_in` in IDLE, GAP and SEND → no state change, bit count unchanged.
- With WS2812_SCHED_WDT_EN, CNT_BIT_TMO=16: bench withholds `bit_done_in` after bit 5 → `frame_err_out` pulse 16 cycles after entering WAIT, busy low, no `frame_done_out`. Without the macro, the same stimulus stalls in WAIT with `frame_err_out`=0.
